// File: rtl/mseq_pkg.sv
// Shared types and microword layout helpers for the microcoded 6502 control sequencer.
// Microword layout, MSB to LSB: {ctrl[CW-1:0], mode[1:0], next[UAW-1:0]}.
package mseq_pkg;

   typedef enum logic [1:0] {
      HALT   = 2'd0,
      FETCH  = 2'd1,
      DECODE = 2'd2,
      EXEC   = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      MODE_INC  = 2'd0,
      MODE_JMP  = 2'd1,
      MODE_COND = 2'd2,
      MODE_END  = 2'd3
   } mode_e;

   localparam int UA_FETCH = 0;

   function automatic int mw_width(input int cw, input int uaw);
      return cw + 2 + uaw;
   endfunction

   function automatic int mode_lsb(input int uaw);
      return uaw;
   endfunction

   function automatic int ctrl_lsb(input int uaw);
      return uaw + 2;
   endfunction

endpackage

// File: rtl/mseq_if.sv
// Handshake/bus bundle between the host/datapath and micro_sequencer.
// The rdy stall input exists only when MSEQ_RDY_EN is defined.
interface mseq_if #(
   parameter int CW  = 48,
   parameter int UAW = 6,
   parameter int OPW = 8
);
   logic [OPW-1:0]      op;
   logic                cond;
`ifdef MSEQ_RDY_EN
   logic                rdy;
`endif
   logic                start;
   logic                uc_we;
   logic [UAW-1:0]      uc_addr;
   logic [CW+2+UAW-1:0] uc_wdata;
   logic                dt_we;
   logic [OPW-1:0]      dt_addr;
   logic [UAW:0]        dt_wdata;
   logic [CW-1:0]       ctrl;
   logic                sync;
   logic [UAW-1:0]      uaddr;
   logic                busy;
   logic                illegal;

   modport master (
`ifdef MSEQ_RDY_EN
      output rdy,
`endif
      output op, cond, start, uc_we, uc_addr, uc_wdata, dt_we, dt_addr, dt_wdata,
      input  ctrl, sync, uaddr, busy, illegal
   );

   modport slave (
`ifdef MSEQ_RDY_EN
      input  rdy,
`endif
      input  op, cond, start, uc_we, uc_addr, uc_wdata, dt_we, dt_addr, dt_wdata,
      output ctrl, sync, uaddr, busy, illegal
   );
endinterface

// File: rtl/mseq_store.sv
// Microcode RAM and opcode dispatch table with combinational reads.
// A write to the word being read is forwarded so it is visible on the next cycle.
module mseq_store
   import mseq_pkg::*;
#(
   parameter int CW  = 48,
   parameter int UAW = 6,
   parameter int OPW = 8
) (
   input  logic                          clk,
   input  logic                          uc_we,
   input  logic [UAW-1:0]                uc_addr,
   input  logic [mw_width(CW,UAW)-1:0]   uc_wdata,
   input  logic                          dt_we,
   input  logic [OPW-1:0]                dt_addr,
   input  logic [UAW:0]                  dt_wdata,
   input  logic [UAW-1:0]                uc_raddr,
   output logic [mw_width(CW,UAW)-1:0]   uc_rdata,
   input  logic [OPW-1:0]                dt_raddr,
   output logic                          dt_valid,
   output logic [UAW-1:0]                dt_start
);
   localparam int MW = mw_width(CW, UAW);

   logic [MW-1:0] uc_mem [2**UAW];
   logic [UAW:0]  dt_mem [2**OPW];

   always_ff @(posedge clk) begin
      if (uc_we) uc_mem[uc_addr] <= uc_wdata;
      if (dt_we) dt_mem[dt_addr] <= dt_wdata;
   end

   assign uc_rdata = (uc_we && (uc_addr == uc_raddr)) ? uc_wdata : uc_mem[uc_raddr];
   assign dt_valid = dt_mem[dt_raddr][UAW];
   assign dt_start = dt_mem[dt_raddr][UAW-1:0];

endmodule

// File: rtl/micro_sequencer.sv
// Microcoded control sequencer: FSM, instruction register and registered control outputs.
// Optional stall input rdy is enabled by defining MSEQ_RDY_EN.
module micro_sequencer
   import mseq_pkg::*;
#(
   parameter int CW  = 48,
   parameter int UAW = 6,
   parameter int OPW = 8
) (
   input  logic clk,
   input  logic clr_n,
   mseq_if.slave bus
);
   localparam int MW       = mw_width(CW, UAW);
   localparam int MODE_LSB = mode_lsb(UAW);
   localparam int CTRL_LSB = ctrl_lsb(UAW);

   state_e         state_reg;
   logic [UAW-1:0] uaddr_reg;
   logic [OPW-1:0] ir_reg;
   logic [CW-1:0]  ctrl_reg;
   mode_e          mode_reg;
   logic [UAW-1:0] next_reg;
   logic           sync_reg;
   logic           busy_reg;
   logic           illegal_reg;

   logic [UAW-1:0] ua_next;
   logic [MW-1:0]  uc_rword;
   logic           dt_valid;
   logic [UAW-1:0] dt_start;
   logic           advance;
   logic           in_halt;

`ifdef MSEQ_RDY_EN
   assign advance = bus.rdy;
`else
   assign advance = 1'b1;
`endif

   assign in_halt = (state_reg == HALT);

   // The store is read at the address the next cycle will hold, so ctrl can be registered.
   always_comb begin
      ua_next = UAW'(UA_FETCH);
      case (state_reg)
         DECODE: ua_next = dt_start;
         EXEC: begin
            case (mode_reg)
               MODE_INC:  ua_next = uaddr_reg + UAW'(1);
               MODE_JMP:  ua_next = next_reg;
               MODE_COND: ua_next = bus.cond ? next_reg : uaddr_reg + UAW'(1);
               MODE_END:  ua_next = UAW'(UA_FETCH);
               default:   ua_next = UAW'(UA_FETCH);
            endcase
         end
         default: ua_next = UAW'(UA_FETCH);
      endcase
   end

   mseq_store #(.CW(CW), .UAW(UAW), .OPW(OPW)) u_store (
      .clk      (clk),
      .uc_we    (bus.uc_we && in_halt),
      .uc_addr  (bus.uc_addr),
      .uc_wdata (bus.uc_wdata),
      .dt_we    (bus.dt_we && in_halt),
      .dt_addr  (bus.dt_addr),
      .dt_wdata (bus.dt_wdata),
      .uc_raddr (ua_next),
      .uc_rdata (uc_rword),
      .dt_raddr (ir_reg),
      .dt_valid (dt_valid),
      .dt_start (dt_start)
   );

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_reg   <= HALT;
         uaddr_reg   <= '0;
         ir_reg      <= '0;
         ctrl_reg    <= '0;
         mode_reg    <= MODE_INC;
         next_reg    <= '0;
         sync_reg    <= 1'b0;
         busy_reg    <= 1'b0;
         illegal_reg <= 1'b0;
      end else begin
         case (state_reg)
            HALT: begin
               ctrl_reg <= '0;
               sync_reg <= 1'b0;
               busy_reg <= 1'b0;
               if (bus.start) begin
                  state_reg   <= FETCH;
                  uaddr_reg   <= ua_next;
                  ctrl_reg    <= uc_rword[CTRL_LSB +: CW];
                  mode_reg    <= mode_e'(uc_rword[MODE_LSB +: 2]);
                  next_reg    <= uc_rword[UAW-1:0];
                  sync_reg    <= 1'b1;
                  busy_reg    <= 1'b1;
                  illegal_reg <= 1'b0;
               end
            end
            FETCH: begin
               if (advance) begin
                  ir_reg    <= bus.op;
                  state_reg <= DECODE;
                  ctrl_reg  <= '0;
                  sync_reg  <= 1'b0;
               end
            end
            DECODE: begin
               if (advance) begin
                  if (dt_valid) begin
                     state_reg <= EXEC;
                     uaddr_reg <= ua_next;
                     ctrl_reg  <= uc_rword[CTRL_LSB +: CW];
                     mode_reg  <= mode_e'(uc_rword[MODE_LSB +: 2]);
                     next_reg  <= uc_rword[UAW-1:0];
                  end else begin
                     state_reg   <= HALT;
                     uaddr_reg   <= '0;
                     busy_reg    <= 1'b0;
                     illegal_reg <= 1'b1;
                  end
               end
            end
            EXEC: begin
               if (advance) begin
                  uaddr_reg <= ua_next;
                  ctrl_reg  <= uc_rword[CTRL_LSB +: CW];
                  mode_reg  <= mode_e'(uc_rword[MODE_LSB +: 2]);
                  next_reg  <= uc_rword[UAW-1:0];
                  if (mode_reg == MODE_END) begin
                     state_reg <= FETCH;
                     sync_reg  <= 1'b1;
                  end
               end
            end
            default: state_reg <= HALT;
         endcase
      end
   end

   assign bus.ctrl    = ctrl_reg;
   assign bus.sync    = sync_reg;
   assign bus.uaddr   = uaddr_reg;
   assign bus.busy    = busy_reg;
   assign bus.illegal = illegal_reg;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed self-checking bench for micro_sequencer; exercises the stall path when MSEQ_RDY_EN is defined.
module tb_micro_sequencer;
   logic clk = 1'b0;
   logic clr_n;
   int   tests = 0;
   int   fails = 0;

   localparam logic [47:0] CF  = 48'hF00D_0000_0001;
   localparam logic [47:0] CF2 = 48'hF00D_0000_0002;
   localparam logic [47:0] C5  = 48'h0005_A5A5_0005;
   localparam logic [47:0] C6  = 48'h0006_0000_6666;
   localparam logic [47:0] C10 = 48'h0010_1010_0010;
   localparam logic [47:0] C11 = 48'h0011_0000_1111;
   localparam logic [47:0] C20 = 48'h0020_2020_2020;
   localparam logic [47:0] C63 = 48'h0063_6363_6363;
   localparam logic [47:0] CX  = 48'hBAD0_BAD0_BAD0;

   mseq_if #(.CW(48), .UAW(6), .OPW(8)) bus ();

   micro_sequencer #(.CW(48), .UAW(6), .OPW(8)) dut (
      .clk   (clk),
      .clr_n (clr_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic uc_write(input logic [5:0] a, input logic [47:0] c, input logic [1:0] m,
                           input logic [5:0] n);
      bus.uc_we    = 1'b1;
      bus.uc_addr  = a;
      bus.uc_wdata = {c, m, n};
      step();
      bus.uc_we    = 1'b0;
   endtask

   task automatic dt_write(input logic [7:0] a, input logic v, input logic [5:0] s);
      bus.dt_we    = 1'b1;
      bus.dt_addr  = a;
      bus.dt_wdata = {v, s};
      step();
      bus.dt_we    = 1'b0;
   endtask

   initial begin
      clr_n        = 1'b0;
      bus.op       = '0;
      bus.cond     = 1'b0;
      bus.start    = 1'b0;
      bus.uc_we    = 1'b0;
      bus.uc_addr  = '0;
      bus.uc_wdata = '0;
      bus.dt_we    = 1'b0;
      bus.dt_addr  = '0;
      bus.dt_wdata = '0;
`ifdef MSEQ_RDY_EN
      bus.rdy      = 1'b1;
`endif
      step(2);
      chk("rst_ctrl", 64'(bus.ctrl), 64'h0);
      chk("rst_sync", 64'(bus.sync), 64'h0);
      chk("rst_busy", 64'(bus.busy), 64'h0);
      chk("rst_illegal", 64'(bus.illegal), 64'h0);
      chk("rst_uaddr", 64'(bus.uaddr), 64'h0);
      clr_n = 1'b1;
      step();
      chk("halt_busy", 64'(bus.busy), 64'h0);

      // Program load; uc[6] and dt[A9] are written on the same edge
      uc_write(6'd0, CF, 2'd3, 6'd0);
      uc_write(6'd5, C5, 2'd0, 6'd0);
      bus.uc_we = 1'b1; bus.uc_addr = 6'd6; bus.uc_wdata = {C6, 2'd3, 6'd0};
      bus.dt_we = 1'b1; bus.dt_addr = 8'hA9; bus.dt_wdata = {1'b1, 6'd5};
      step();
      bus.uc_we = 1'b0; bus.dt_we = 1'b0;
      dt_write(8'h02, 1'b0, 6'd0);
      dt_write(8'h10, 1'b1, 6'd10);
      dt_write(8'h3F, 1'b1, 6'd63);
      uc_write(6'd10, C10, 2'd2, 6'd20);
      uc_write(6'd11, C11, 2'd3, 6'd0);
      uc_write(6'd20, C20, 2'd3, 6'd0);
      uc_write(6'd63, C63, 2'd0, 6'd0);

      // LDA immediate
      bus.op = 8'hA9; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("lda_fetch_sync", 64'(bus.sync), 64'h1);
      chk("lda_fetch_ctrl", 64'(bus.ctrl), 64'(CF));
      chk("lda_fetch_uaddr", 64'(bus.uaddr), 64'h0);
      chk("lda_fetch_busy", 64'(bus.busy), 64'h1);
      step();
      chk("lda_dec_sync", 64'(bus.sync), 64'h0);
      chk("lda_dec_ctrl", 64'(bus.ctrl), 64'h0);
      step();
      chk("lda_ex5_uaddr", 64'(bus.uaddr), 64'd5);
      chk("lda_ex5_ctrl", 64'(bus.ctrl), 64'(C5));
      bus.uc_we = 1'b1; bus.uc_addr = 6'd5; bus.uc_wdata = {CX, 2'd0, 6'd0};
      step();
      bus.uc_we = 1'b0;
      chk("lda_ex6_uaddr", 64'(bus.uaddr), 64'd6);
      chk("lda_ex6_ctrl", 64'(bus.ctrl), 64'(C6));
      step();
      chk("lda_next_sync", 64'(bus.sync), 64'h1);
      chk("lda_next_ctrl", 64'(bus.ctrl), 64'(CF));
      bus.op = 8'h02;

      // Illegal opcode
      step();
      chk("ill_dec_ctrl", 64'(bus.ctrl), 64'h0);
      step();
      chk("ill_flag", 64'(bus.illegal), 64'h1);
      chk("ill_busy", 64'(bus.busy), 64'h0);
      chk("ill_sync", 64'(bus.sync), 64'h0);

      // start clears illegal; COND taken then not taken
      bus.op = 8'h10; bus.cond = 1'b1; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("start_clr_illegal", 64'(bus.illegal), 64'h0);
      chk("cond_fetch_sync", 64'(bus.sync), 64'h1);
      step(2);
      chk("cond_ex_uaddr", 64'(bus.uaddr), 64'd10);
      chk("cond_ex_ctrl", 64'(bus.ctrl), 64'(C10));
      step();
      chk("cond_taken_uaddr", 64'(bus.uaddr), 64'd20);
      chk("cond_taken_ctrl", 64'(bus.ctrl), 64'(C20));
      bus.cond = 1'b0;
      step();
      chk("cond_refetch_sync", 64'(bus.sync), 64'h1);
      step(2);
      chk("cond2_ex_uaddr", 64'(bus.uaddr), 64'd10);
      step();
      chk("cond_nt_uaddr", 64'(bus.uaddr), 64'd11);
      chk("cond_nt_ctrl", 64'(bus.ctrl), 64'(C11));

      // INC wrap from 63 to 0
      bus.op = 8'h3F;
      step(3);
      chk("wrap_ex_uaddr", 64'(bus.uaddr), 64'd63);
      chk("wrap_ex_ctrl", 64'(bus.ctrl), 64'(C63));
      step();
      chk("wrap_uaddr", 64'(bus.uaddr), 64'd0);
      chk("wrap_ctrl", 64'(bus.ctrl), 64'(CF));
      chk("wrap_sync", 64'(bus.sync), 64'h0);
      step();
      chk("wrap_end_sync", 64'(bus.sync), 64'h1);

      // Second LDA: uc[5] must be unchanged by the gated write
      bus.op = 8'hA9;
      step(2);
      chk("gate_uaddr", 64'(bus.uaddr), 64'd5);
      chk("gate_ctrl", 64'(bus.ctrl), 64'(C5));
`ifdef MSEQ_RDY_EN
      bus.rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_uaddr", 64'(bus.uaddr), 64'd5);
         chk("stall_ctrl", 64'(bus.ctrl), 64'(C5));
      end
      bus.rdy = 1'b1;
`endif
      step();
      chk("lda2_ex6_uaddr", 64'(bus.uaddr), 64'd6);
      step();
      chk("lda2_end_sync", 64'(bus.sync), 64'h1);
      bus.op = 8'h02;
      step(2);
      chk("halt2_busy", 64'(bus.busy), 64'h0);

      // Write in HALT together with start; new fetch word seen in the FETCH cycle
      bus.uc_we = 1'b1; bus.uc_addr = 6'd0; bus.uc_wdata = {CF2, 2'd3, 6'd0};
      bus.op = 8'hA9; bus.start = 1'b1;
      step();
      bus.uc_we = 1'b0; bus.start = 1'b0;
      chk("wr_start_ctrl", 64'(bus.ctrl), 64'(CF2));
      chk("wr_start_sync", 64'(bus.sync), 64'h1);
      step(2);
      chk("pre_rst_uaddr", 64'(bus.uaddr), 64'd5);

      // Asynchronous reset mid-EXEC
      clr_n = 1'b0;
      #1;
      chk("arst_ctrl", 64'(bus.ctrl), 64'h0);
      chk("arst_busy", 64'(bus.busy), 64'h0);
      chk("arst_sync", 64'(bus.sync), 64'h0);
      chk("arst_uaddr", 64'(bus.uaddr), 64'h0);
      step();
      clr_n = 1'b1;
      step();
      chk("post_rst_busy", 64'(bus.busy), 64'h0);
      chk("post_rst_ctrl", 64'(bus.ctrl), 64'h0);

      // Store survives reset
      bus.op = 8'h02; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("post_rst_fetch_sync", 64'(bus.sync), 64'h1);
      chk("post_rst_fetch_ctrl", 64'(bus.ctrl), 64'(CF2));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
